// File: rtl/xoodoo_rdi_gen_pkg.sv
// Shared constants, FSM encoding and the xorshift32 step used by the rdi generator.
package xoodoo_rdi_gen_pkg;

  localparam int          NUM_LANES    = 12;
  localparam int          XOODOO_RDI_W = 32 * NUM_LANES;
  localparam logic [31:0] ZERO_SUB     = 32'h9E3779B9;

  localparam int XS_SHL_A = 13;
  localparam int XS_SHR_B = 17;
  localparam int XS_SHL_C = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEED = 2'd1,
    ST_RUN  = 2'd2
  } rdiState_e;

  function automatic logic [31:0] xsStep(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << XS_SHL_A);
    y = y ^ (y >> XS_SHR_B);
    y = y ^ (y << XS_SHL_C);
    return y;
  endfunction

endpackage

// File: rtl/xoodoo_rdi_fifo2.sv
// Two-entry FIFO with a registered head; supports push and pop in the same cycle.
module xoodoo_rdi_fifo2 #(
  parameter int W = 384
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o,
  output logic         valid_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic [1:0]   count_q, count_d;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      case ({push_i, pop_i})
        2'b10: begin
          if (count_q == 2'd0) head_d = data_i;
          else                 tail_d = data_i;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          head_d  = tail_q;
          count_d = count_q - 2'd1;
        end
        // Simultaneous push/pop: the head advances and the new word lands behind it.
        2'b11: begin
          if (count_q == 2'd2) begin
            head_d = tail_q;
            tail_d = data_i;
          end else begin
            head_d = data_i;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign data_o  = head_q;
  assign valid_o = (count_q != 2'd0);
  assign count_o = count_q;

endmodule

// File: rtl/xoodoo_rdi_gen.sv
// Twelve-lane xorshift32 randomness source feeding the masked Xoodoo rdi port.
module xoodoo_rdi_gen
  import xoodoo_rdi_gen_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    seed_start_i,
  input  logic [31:0]             seed_word_i,
  input  logic                    seed_valid_i,
  output logic                    seeded_o,
  output logic [XOODOO_RDI_W-1:0] rdi,
  output logic                    rdi_valid,
  input  logic                    rdi_ready,
  output logic [15:0]             rdi_count_o
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_LANES - 1);

  rdiState_e state_q, state_d;
  logic [3:0]  seedIdx_q, seedIdx_d;
  logic [15:0] rdiCount_q;
  logic [31:0] lane_q   [NUM_LANES];
  logic [31:0] laneNext [NUM_LANES];
  logic [XOODOO_RDI_W-1:0] pushWord;
  logic [31:0] seedVal;
  logic [1:0]  fifoCount;
  logic        loadLane, flush, push, pop;

  for (genvar k = 0; k < NUM_LANES; k++) begin : gLane
    assign laneNext[k]           = xsStep(lane_q[k]);
    assign pushWord[32*k +: 32]  = laneNext[k];
  end

  assign seedVal = (seed_word_i == 32'd0) ? ZERO_SUB : seed_word_i;

  always_comb begin
    state_d   = state_q;
    seedIdx_d = seedIdx_q;
    loadLane  = 1'b0;
    flush     = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    if (seed_start_i) begin
      state_d   = ST_SEED;
      seedIdx_d = '0;
      flush     = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_SEED: begin
          if (seed_valid_i) begin
            loadLane = 1'b1;
            if (seedIdx_q == LAST_IDX) begin
              state_d   = ST_RUN;
              seedIdx_d = '0;
            end else begin
              seedIdx_d = seedIdx_q + 4'd1;
            end
          end
        end
        // Lanes only step when a word is actually written, so no randomness is dropped.
        ST_RUN: begin
          pop  = rdi_valid & rdi_ready;
          push = (fifoCount < 2'd2) | pop;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      seedIdx_q  <= '0;
      rdiCount_q <= '0;
    end else begin
      state_q   <= state_d;
      seedIdx_q <= seedIdx_d;
      if (flush)    rdiCount_q <= '0;
      else if (pop) rdiCount_q <= rdiCount_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < NUM_LANES; k++) lane_q[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_LANES; k++) begin
        if (loadLane && (seedIdx_q == 4'(k))) lane_q[k] <= seedVal;
        else if (push)                        lane_q[k] <= laneNext[k];
      end
    end
  end

  xoodoo_rdi_fifo2 #(
    .W (XOODOO_RDI_W)
  ) uFifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (pushWord),
    .data_o  (rdi),
    .valid_o (rdi_valid),
    .count_o (fifoCount)
  );

  assign seeded_o    = (state_q == ST_RUN);
  assign rdi_count_o = rdiCount_q;

endmodule
